// File: rtl/display_ctrl.sv
`default_nettype none
// ============================================================================
// display_ctrl : frame-buffered 8-digit seven-segment scan driver
// Revision 1.0
// ============================================================================
module display_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_WIDTH   = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [7:0] dec_cat,
    output logic       frame_upd
);

    localparam logic [1:0] c_st_error = 2'b00;
    localparam logic [1:0] c_st_ready = 2'b10;
    localparam logic [1:0] c_st_print = 2'b11;
    localparam logic [3:0] c_blank_code = 4'hF;
    localparam logic [DIV_WIDTH-1:0] c_div_max = DIV_WIDTH'(REFRESH_DIV - 1);

    logic [3:0]           r_work   [8];
    logic [3:0]           r_shadow [8];
    logic [3:0]           w_work_next [8];
    logic [1:0]           r_status_q;
    logic                 r_err_mode;
    logic [2:0]           r_scan;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_capture;
    logic                 w_commit;
    logic [2:0]           w_widx;
    logic [3:0]           w_wdata;
    logic [7:0]           w_nz;
    logic                 w_acc;
    logic [7:0]           w_pattern;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    assign w_capture = (status == c_st_print) && (pos >= 4'd1) && (pos <= 4'd8);
    assign w_commit  = (r_status_q == c_st_print) && (status == c_st_ready);
    assign w_widx    = 3'(pos - 4'd1);
    assign w_wdata   = (data > 4'd9) ? c_blank_code : data;

    // Commit sees the working buffer as it will be after this cycle's capture.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_work_next[i] = r_work[i];
        end
        if (w_capture) begin
            w_work_next[w_widx] = w_wdata;
        end
    end

    // w_nz[i] is set when any digit at or above i is non-zero.
    always_comb begin
        w_nz  = '0;
        w_acc = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            w_acc   = w_acc | (r_shadow[i] != 4'd0);
            w_nz[i] = w_acc;
        end
    end

    always_comb begin
        w_pattern = 8'hFF;
        if (r_err_mode) begin
            case (r_scan)
                3'd3:    w_pattern = 8'h86;
                3'd2:    w_pattern = 8'hAF;
                3'd1:    w_pattern = 8'hAF;
                3'd0:    w_pattern = 8'hA3;
                default: w_pattern = 8'hFF;
            endcase
        end else if ((r_scan == 3'd0) || w_nz[r_scan]) begin
            w_pattern = seg7(r_shadow[r_scan]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_work[i]   <= 4'd0;
                r_shadow[i] <= 4'd0;
            end
            r_status_q <= c_st_ready;
            r_err_mode <= 1'b0;
            r_scan     <= 3'd0;
            r_div      <= '0;
            an         <= 8'hFF;
            dec_cat    <= 8'hFF;
            frame_upd  <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_work[i] <= w_work_next[i];
                if (w_commit) begin
                    r_shadow[i] <= w_work_next[i];
                end
            end
            r_status_q <= status;
            r_err_mode <= (status == c_st_error);
            frame_upd  <= w_commit;
            if (r_div == c_div_max) begin
                r_div  <= '0;
                r_scan <= r_scan + 3'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            an      <= ~(8'd1 << r_scan);
            dec_cat <= w_pattern;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_ctrl.sv
`default_nettype none
// ============================================================================
// tb_display_ctrl : directed self-checking bench for display_ctrl
// Revision 1.0
// ============================================================================
module tb_display_ctrl;

    logic       clock;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [7:0] dec_cat;
    logic       frame_upd;

    int n_checks;
    int n_fail;
    int upd_cnt;
    int upd_base;

    display_ctrl #(
        .REFRESH_DIV(4),
        .DIV_WIDTH  (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .status   (status),
        .data     (data),
        .pos      (pos),
        .an       (an),
        .dec_cat  (dec_cat),
        .frame_upd(frame_upd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_upd === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for digit idx to be scanned, then compares its segments.
    task automatic check_digit(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] exp_an;
        logic       found;
        exp_an = ~(8'd1 << idx);
        found  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (an == exp_an) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (found) check($sformatf("%s_d%0d", tag, idx), {24'd0, dec_cat}, {24'd0, exp});
        else       check($sformatf("%s_d%0d_timeout", tag, idx), {24'd0, an}, {24'd0, exp_an});
    endtask

    task automatic check_display(input string tag, input logic [63:0] exp);
        for (int i = 0; i < 8; i++) begin
            check_digit(tag, i, exp[8*i +: 8]);
        end
    endtask

    // v[4*i +: 4] is sent at pos i+1.
    task automatic send_digits(input logic [31:0] v);
        status = 2'b11;
        for (int p = 1; p <= 8; p++) begin
            pos  = 4'(p);
            data = v[4*(p-1) +: 4];
            @(negedge clock);
        end
    endtask

    task automatic end_frame();
        status = 2'b10;
        pos    = 4'd0;
        data   = 4'd0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        upd_cnt  = 0;
        reset    = 1'b1;
        status   = 2'b10;
        data     = 4'd0;
        pos      = 4'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_cat", {24'd0, dec_cat}, 32'hFF);
        check("rst_upd", {31'd0, frame_upd}, 32'd0);

        // Scan cadence: each anode held exactly 4 cycles, wrapping 7 -> 0.
        for (int k = 0; k < 36; k++) begin
            @(negedge clock);
            check($sformatf("scan_an_%0d", k), {24'd0, an}, {24'd0, ~(8'd1 << ((k / 4) % 8))});
            check($sformatf("scan_cat_%0d", k), {24'd0, dec_cat},
                  (((k / 4) % 8) == 0) ? 32'hC0 : 32'hFF);
        end

        upd_base = upd_cnt;
        send_digits(32'h0000_0024);
        end_frame();
        check("f1_upd", upd_cnt - upd_base, 1);
        check_display("f1", 64'hFFFF_FFFF_FFFF_A499);

        upd_base = upd_cnt;
        send_digits(32'h5000_0007);
        end_frame();
        check("f2_upd", upd_cnt - upd_base, 1);
        check_display("f2", 64'h92C0_C0C0_C0C0_C0F8);

        upd_base = upd_cnt;
        status   = 2'b00;
        repeat (3) @(negedge clock);
        check_display("err", 64'hFFFF_FFFF_86AF_AFA3);
        status = 2'b10;
        repeat (3) @(negedge clock);
        check_display("resume", 64'h92C0_C0C0_C0C0_C0F8);
        check("resume_upd", upd_cnt - upd_base, 0);

        // Out-of-range positions ignored; data above 9 blanks its digit.
        upd_base = upd_cnt;
        send_digits(32'h0000_01C3);
        pos  = 4'd0;
        data = 4'd8;
        @(negedge clock);
        pos = 4'd9;
        @(negedge clock);
        end_frame();
        check("f3_upd", upd_cnt - upd_base, 1);
        check_display("f3", 64'hFFFF_FFFF_FFF9_FFB0);

        upd_base = upd_cnt;
        status   = 2'b11;
        for (int p = 1; p <= 3; p++) begin
            pos  = 4'(p);
            data = 4'(p + 4);
            @(negedge clock);
        end
        reset  = 1'b1;
        status = 2'b10;
        pos    = 4'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_mid_upd", upd_cnt - upd_base, 0);
        check_display("rst_mid", 64'hFFFF_FFFF_FFFF_FFC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
